// File: rtl/calendar_date_counter.sv
// Day/month/year register bank. Advances on day_tick, accepts a validated date
// load, and drives the external month-length lookup that feeds modulo_day.
module calendar_date_counter #(
  parameter int unsigned YEAR_MAX   = 9999,
  parameter int unsigned RESET_YEAR = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        day_tick,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [4:0]  set_day,
  input  logic [3:0]  set_month,
  input  logic [13:0] set_year,
  output logic        set_done,
  output logic        set_error,
  output logic [3:0]  lookup_month,
  output logic        lookup_leap,
  input  logic [4:0]  modulo_day,
  output logic [4:0]  day,
  output logic [3:0]  month,
  output logic [13:0] year,
  output logic        leap_year,
  output logic        month_wrap,
  output logic        year_wrap
);

  localparam logic [13:0] YMAX = YEAR_MAX[13:0];
  localparam logic [13:0] RYEAR = RESET_YEAR[13:0];

  typedef enum logic {
    IDLE,
    VALIDATE
  } state_t;

  state_t state, state_d;

  logic [4:0]  pend_day;
  logic [3:0]  pend_month;
  logic [13:0] pend_year;
  logic        pend_leap;
  logic        tick_pending;

  logic        accept;
  logic        advance;
  logic        day_last;
  logic [13:0] next_year;
  logic        month_ok;
  logic        year_ok;
  logic        day_ok;
  logic        load_ok;

  function automatic logic is_leap(input logic [13:0] y);
    return (y[1:0] == 2'b00) &&
           (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and state-decoded outputs (handshake and lookup source).
  always_comb begin
    state_d      = state;
    set_ready    = 1'b0;
    lookup_month = month;
    lookup_leap  = leap_year;
    case (state)
      IDLE: begin
        set_ready = 1'b1;
        if (set_valid) state_d = VALIDATE;
      end
      VALIDATE: begin
        lookup_month = pend_month;
        lookup_leap  = pend_leap;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Date arithmetic and load legality; month range gates any use of modulo_day.
  always_comb begin
    accept    = set_valid && (state == IDLE);
    advance   = (state == IDLE) && (day_tick || tick_pending);
    day_last  = !(day < modulo_day);
    next_year = (year == YMAX) ? '0 : year + 14'd1;
    month_ok  = (pend_month >= 4'd1) && (pend_month <= 4'd12);
    year_ok   = (pend_year <= YMAX);
    day_ok    = (pend_day != 5'd0) && (pend_day <= modulo_day);
    load_ok   = month_ok && year_ok && day_ok;
  end

  // Date registers, pending load, deferred tick and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      day          <= 5'd1;
      month        <= 4'd1;
      year         <= RYEAR;
      leap_year    <= is_leap(RYEAR);
      pend_day     <= '0;
      pend_month   <= '0;
      pend_year    <= '0;
      pend_leap    <= 1'b0;
      tick_pending <= 1'b0;
      set_done     <= 1'b0;
      set_error    <= 1'b0;
      month_wrap   <= 1'b0;
      year_wrap    <= 1'b0;
    end else begin
      set_done   <= 1'b0;
      set_error  <= 1'b0;
      month_wrap <= 1'b0;
      year_wrap  <= 1'b0;
      if (state == IDLE) begin
        tick_pending <= 1'b0;
        if (advance) begin
          if (!day_last) begin
            day <= day + 5'd1;
          end else begin
            day        <= 5'd1;
            month_wrap <= 1'b1;
            if (month == 4'd12) begin
              month     <= 4'd1;
              year      <= next_year;
              leap_year <= is_leap(next_year);
              year_wrap <= 1'b1;
            end else begin
              month <= month + 4'd1;
            end
          end
        end
        if (accept) begin
          pend_day   <= set_day;
          pend_month <= set_month;
          pend_year  <= set_year;
          pend_leap  <= is_leap(set_year);
        end
      end else begin
        // A tick seen while validating survives only if the load is rejected.
        if (load_ok) begin
          day          <= pend_day;
          month        <= pend_month;
          year         <= pend_year;
          leap_year    <= pend_leap;
          set_done     <= 1'b1;
          tick_pending <= 1'b0;
        end else begin
          set_error    <= 1'b1;
          tick_pending <= day_tick;
        end
      end
    end
  end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Directed bench for calendar_date_counter with a month-length lookup model.
module tb_calendar_date_counter;

  logic        clk;
  logic        reset;
  logic        day_tick;
  logic        set_valid;
  logic        set_ready;
  logic [4:0]  set_day;
  logic [3:0]  set_month;
  logic [13:0] set_year;
  logic        set_done;
  logic        set_error;
  logic [3:0]  lookup_month;
  logic        lookup_leap;
  logic [4:0]  modulo_day;
  logic [4:0]  day;
  logic [3:0]  month;
  logic [13:0] year;
  logic        leap_year;
  logic        month_wrap;
  logic        year_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int mw_count;
  int yw_count;

  calendar_date_counter #(.YEAR_MAX(9999), .RESET_YEAR(2000)) dut (
    .clk(clk), .reset(reset), .day_tick(day_tick), .set_valid(set_valid),
    .set_ready(set_ready), .set_day(set_day), .set_month(set_month),
    .set_year(set_year), .set_done(set_done), .set_error(set_error),
    .lookup_month(lookup_month), .lookup_leap(lookup_leap),
    .modulo_day(modulo_day), .day(day), .month(month), .year(year),
    .leap_year(leap_year), .month_wrap(month_wrap), .year_wrap(year_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Month-length lookup stage; out-of-range months return 31.
  always_comb begin
    case (lookup_month)
      4'd2:                      modulo_day = lookup_leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   modulo_day = 5'd30;
      default:                   modulo_day = 5'd31;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_date(input int y, input int m, input int d);
    return {9'd0, y[13:0], m[3:0], d[4:0]};
  endfunction

  function automatic logic [31:0] cur_date();
    return {9'd0, year, month, day};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    day_tick = 1'b1;
    cycle();
    day_tick = 1'b0;
  endtask

  // Present a load, optionally tick during VALIDATE, and check the outcome pulses.
  task automatic do_load(input string tag, input logic [4:0] d, input logic [3:0] m,
                         input logic [13:0] y, input bit exp_ok, input bit tick_mid);
    set_valid = 1'b1;
    set_day   = d;
    set_month = m;
    set_year  = y;
    cycle();
    set_valid = 1'b0;
    check_eq({tag, "_ready_low"}, 32'(set_ready), 32'd0);
    day_tick = tick_mid;
    cycle();
    day_tick = 1'b0;
    check_eq({tag, "_done"},  32'(set_done),  32'(exp_ok));
    check_eq({tag, "_error"}, 32'(set_error), 32'(!exp_ok));
    check_eq({tag, "_ready"}, 32'(set_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    day_tick  = 1'b0;
    set_valid = 1'b0;
    set_day   = '0;
    set_month = '0;
    set_year  = '0;
    cycle();
    cycle();
    reset = 1'b0;

    check_eq("rst_date",  cur_date(), pack_date(2000, 1, 1));
    check_eq("rst_leap",  32'(leap_year), 32'd1);
    check_eq("rst_ready", 32'(set_ready), 32'd1);
    check_eq("rst_pulses", {28'd0, set_done, set_error, month_wrap, year_wrap}, 32'd0);

    mw_count = 0;
    yw_count = 0;
    for (int i = 0; i < 31; i++) begin
      tick_once();
      mw_count += int'(month_wrap);
      yw_count += int'(year_wrap);
    end
    check_eq("jan_date", cur_date(), pack_date(2000, 2, 1));
    check_eq("jan_mwrap", 32'(mw_count), 32'd1);
    check_eq("jan_ywrap", 32'(yw_count), 32'd0);

    do_load("ld2000", 5'd28, 4'd2, 14'd2000, 1'b1, 1'b0);
    check_eq("ld2000_date", cur_date(), pack_date(2000, 2, 28));
    tick_once();
    check_eq("feb29_date", cur_date(), pack_date(2000, 2, 29));
    check_eq("feb29_mwrap", 32'(month_wrap), 32'd0);

    do_load("ld1900", 5'd28, 4'd2, 14'd1900, 1'b1, 1'b0);
    check_eq("ld1900_leap", 32'(leap_year), 32'd0);
    tick_once();
    check_eq("mar1_date", cur_date(), pack_date(1900, 3, 1));
    check_eq("mar1_mwrap", 32'(month_wrap), 32'd1);
    check_eq("mar1_leap", 32'(leap_year), 32'd0);

    do_load("ldmax", 5'd31, 4'd12, 14'd9999, 1'b1, 1'b0);
    check_eq("ldmax_leap", 32'(leap_year), 32'd0);
    tick_once();
    check_eq("y0_date", cur_date(), pack_date(0, 1, 1));
    check_eq("y0_pulses", {30'd0, month_wrap, year_wrap}, 32'd3);
    check_eq("y0_leap", 32'(leap_year), 32'd1);

    do_load("bad_feb29", 5'd29, 4'd2, 14'd2023, 1'b0, 1'b0);
    check_eq("bad_feb29_date", cur_date(), pack_date(0, 1, 1));
    do_load("bad_month", 5'd1, 4'd13, 14'd2024, 1'b0, 1'b0);
    check_eq("bad_month_date", cur_date(), pack_date(0, 1, 1));
    do_load("bad_year", 5'd1, 4'd1, 14'd10000, 1'b0, 1'b0);
    check_eq("bad_year_date", cur_date(), pack_date(0, 1, 1));
    do_load("bad_day0", 5'd0, 4'd1, 14'd2024, 1'b0, 1'b1);
    check_eq("bad_day0_date", cur_date(), pack_date(0, 1, 1));
    cycle();
    check_eq("pend_tick_applied", cur_date(), pack_date(0, 1, 2));
    cycle();
    check_eq("pend_tick_once", cur_date(), pack_date(0, 1, 2));

    set_valid = 1'b1;
    day_tick  = 1'b1;
    set_day   = 5'd30;
    set_month = 4'd4;
    set_year  = 14'd2024;
    cycle();
    set_valid = 1'b0;
    day_tick  = 1'b0;
    check_eq("sim_tick_applied", cur_date(), pack_date(0, 1, 3));
    check_eq("sim_ready_low", 32'(set_ready), 32'd0);
    cycle();
    check_eq("sim_done", 32'(set_done), 32'd1);
    check_eq("sim_date", cur_date(), pack_date(2024, 4, 30));
    cycle();
    check_eq("sim_date_hold", cur_date(), pack_date(2024, 4, 30));

    set_valid = 1'b1;
    set_day   = 5'd15;
    set_month = 4'd5;
    set_year  = 14'd2024;
    cycle();
    set_valid = 1'b0;
    reset     = 1'b1;
    cycle();
    reset = 1'b0;
    check_eq("rstv_date", cur_date(), pack_date(2000, 1, 1));
    check_eq("rstv_pulses", {30'd0, set_done, set_error}, 32'd0);
    check_eq("rstv_ready", 32'(set_ready), 32'd1);
    check_eq("rstv_leap", 32'(leap_year), 32'd1);
    cycle();
    check_eq("rstv_pulses_after", {30'd0, set_done, set_error}, 32'd0);
    check_eq("rstv_date_after", cur_date(), pack_date(2000, 1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
